rob_multiport: RTL and testbench

//  Parametrised in-order-retire reorder buffer: allocates up to LANES entries/cycle, takes LANES CDB completions/cycle, retires up to LANES entries/cycle in program order.

---
 rtl/rob_if.sv | 46 ++++
 rtl/rob_multiport.sv | 186 ++++++++++++++++++
 tb/tb_rob_multiport.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Reorder buffer bus: dispatch alloc, CDB completions, commit and status.
// master = rename/exec side, slave = the ROB.
interface rob_if #(
  parameter int DEPTH  = 16,
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  localparam int TAG_W = $clog2(DEPTH);

  logic [LANES-1:0]        alloc_valid;
  logic [LANES*REG_W-1:0]  alloc_dest;
  logic [LANES-1:0]        alloc_halt;
  logic                    alloc_ready;
  logic [TAG_W-1:0]        alloc_tag;
  logic [LANES-1:0]        cdb_valid;
  logic [LANES*TAG_W-1:0]  cdb_tag;
  logic [LANES*DATA_W-1:0] cdb_value;
  logic [LANES-1:0]        cdb_flush;
  logic [LANES-1:0]        commit_valid;
  logic [LANES*REG_W-1:0]  commit_dest;
  logic [LANES*DATA_W-1:0] commit_data;
  logic [LANES*TAG_W-1:0]  commit_tag;
  logic                    flush_valid;
  logic [DATA_W-1:0]       flush_target;
  logic                    halted;
  logic [TAG_W:0]          count;
  logic                    empty;
  logic                    full;

  modport master (
    output alloc_valid, alloc_dest, alloc_halt,
    output cdb_valid, cdb_tag, cdb_value, cdb_flush,
    input  alloc_ready, alloc_tag,
    input  commit_valid, commit_dest, commit_data, commit_tag,
    input  flush_valid, flush_target, halted, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_dest, alloc_halt,
    input  cdb_valid, cdb_tag, cdb_value, cdb_flush,
    output alloc_ready, alloc_tag,
    output commit_valid, commit_dest, commit_data, commit_tag,
    output flush_valid, flush_target, halted, count, empty, full
  );
endinterface

// File: rtl/rob_multiport.sv
// Multi-lane in-order-retire reorder buffer with occupancy count,
// alloc backpressure, one-cycle flush state and sticky halt.
module rob_multiport #(
  parameter int DEPTH  = 16,
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input logic  clk,
  input logic  rst_n,
  rob_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t state_q, state_d;

  logic [DEPTH-1:0]  e_valid, e_done, e_flush, e_halt;
  logic [REG_W-1:0]  e_dest  [DEPTH];
  logic [DATA_W-1:0] e_value [DEPTH];
  logic [TAG_W-1:0]  alloc_ptr, commit_ptr;
  logic [CNT_W-1:0]  count_q;

  logic [TAG_W-1:0]  c_idx [LANES];
  logic [TAG_W-1:0]  a_idx [LANES];
  logic [LANES-1:0]  sel, wr;
  logic [CNT_W-1:0]  n_commit, n_alloc;
  logic              do_flush, do_halt, stop, alloc_ok;
  logic [DATA_W-1:0] flush_tgt;

  logic [LANES-1:0]        cv_q;
  logic [LANES*REG_W-1:0]  cd_q;
  logic [LANES*DATA_W-1:0] cdat_q;
  logic [LANES*TAG_W-1:0]  ct_q;
  logic                    fv_q;
  logic [DATA_W-1:0]       ft_q;

  assign alloc_ok = (state_q == RUN) &&
                    (count_q <= CNT_W'(DEPTH - LANES));

  // Retire window stops after the first not-ready, flush or halt entry
  always_comb begin
    sel       = '0;
    wr        = '0;
    n_commit  = '0;
    do_flush  = 1'b0;
    do_halt   = 1'b0;
    flush_tgt = '0;
    stop      = (state_q != RUN);
    for (int k = 0; k < LANES; k++) begin
      c_idx[k] = commit_ptr + TAG_W'(k);
      if (!stop && e_valid[c_idx[k]] && e_done[c_idx[k]]) begin
        sel[k]   = 1'b1;
        n_commit = n_commit + CNT_W'(1);
        if (e_flush[c_idx[k]]) begin
          do_flush  = 1'b1;
          flush_tgt = e_value[c_idx[k]];
          stop      = 1'b1;
        end else if (e_halt[c_idx[k]]) begin
          do_halt = 1'b1;
          stop    = 1'b1;
        end else begin
          wr[k] = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < LANES; i++) begin
      a_idx[i] = alloc_ptr + TAG_W'(i);
      if (bus.alloc_valid[i]) n_alloc = n_alloc + CNT_W'(1);
    end
    if (!alloc_ok) n_alloc = '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (do_flush)     state_d = FLUSH;
        else if (do_halt) state_d = HALT;
      end
      FLUSH:   state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      alloc_ptr  <= '0;
      commit_ptr <= '0;
      count_q    <= '0;
      e_valid    <= '0;
      e_done     <= '0;
      e_flush    <= '0;
      e_halt     <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        e_dest[j]  <= '0;
        e_value[j] <= '0;
      end
      cv_q   <= '0;
      cd_q   <= '0;
      cdat_q <= '0;
      ct_q   <= '0;
      fv_q   <= 1'b0;
      ft_q   <= '0;
    end else begin
      state_q <= state_d;
      cv_q    <= wr;
      fv_q    <= do_flush;
      ft_q    <= flush_tgt;
      for (int k = 0; k < LANES; k++) begin
        cd_q[k*REG_W +: REG_W]    <= e_dest[c_idx[k]];
        cdat_q[k*DATA_W +: DATA_W] <= e_value[c_idx[k]];
        ct_q[k*TAG_W +: TAG_W]    <= c_idx[k];
      end
      if (state_q == RUN) begin
        // Ascending lane order: the highest lane wins on duplicate tags
        for (int i = 0; i < LANES; i++) begin
          if (bus.cdb_valid[i] &&
              e_valid[bus.cdb_tag[i*TAG_W +: TAG_W]]) begin
            e_value[bus.cdb_tag[i*TAG_W +: TAG_W]] <=
              bus.cdb_value[i*DATA_W +: DATA_W];
            e_flush[bus.cdb_tag[i*TAG_W +: TAG_W]] <= bus.cdb_flush[i];
            e_done[bus.cdb_tag[i*TAG_W +: TAG_W]]  <= 1'b1;
          end
        end
        for (int k = 0; k < LANES; k++) begin
          if (sel[k]) begin
            e_valid[c_idx[k]] <= 1'b0;
            e_done[c_idx[k]]  <= 1'b0;
          end
        end
        if (do_flush) begin
          e_valid    <= '0;
          e_done     <= '0;
          e_flush    <= '0;
          e_halt     <= '0;
          alloc_ptr  <= '0;
          commit_ptr <= '0;
          count_q    <= '0;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (alloc_ok && bus.alloc_valid[i]) begin
              e_valid[a_idx[i]] <= 1'b1;
              e_done[a_idx[i]]  <= bus.alloc_halt[i];
              e_flush[a_idx[i]] <= 1'b0;
              e_halt[a_idx[i]]  <= bus.alloc_halt[i];
              e_dest[a_idx[i]]  <= bus.alloc_dest[i*REG_W +: REG_W];
            end
          end
          alloc_ptr  <= alloc_ptr + n_alloc[TAG_W-1:0];
          commit_ptr <= commit_ptr + n_commit[TAG_W-1:0];
          count_q    <= count_q + n_alloc - n_commit;
        end
      end
    end
  end

  assign bus.alloc_ready  = alloc_ok;
  assign bus.alloc_tag    = alloc_ptr;
  assign bus.commit_valid = cv_q;
  assign bus.commit_dest  = cd_q;
  assign bus.commit_data  = cdat_q;
  assign bus.commit_tag   = ct_q;
  assign bus.flush_valid  = fv_q;
  assign bus.flush_target = ft_q;
  assign bus.halted       = (state_q == HALT);
  assign bus.count        = count_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == CNT_W'(DEPTH));

  logic [LANES-1:0] av_inc;
  assign av_inc = bus.alloc_valid + LANES'(1);

  // Dispatch must fill lanes from lane 0 upward
  a_contig: assert property (@(posedge clk) disable iff (!rst_n)
    ((bus.alloc_valid & av_inc) == '0));
endmodule

// File: tb/tb_rob_multiport.sv
// Random + directed bench for rob_multiport: queue-level ROB model
// feeds an expected-commit scoreboard drained by a posedge monitor.
module tb_rob_multiport;
  localparam int DEPTH  = 16;
  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_if #(.DEPTH(DEPTH), .LANES(LANES), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  rob_multiport #(.DEPTH(DEPTH), .LANES(LANES), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int tag; int dest; bit done; bit flush; bit halt; int value;
  } ent_t;
  typedef struct {
    int cyc; bit fl; int lane; int dest; int data; int tag;
  } exp_t;

  ent_t rob[$];
  exp_t expq[$];
  int   m_aptr = 0;
  int   m_st = 0;
  int   edge_n = 0;
  int   total = 0;
  int   bad = 0;
  bit   chk_on = 0;

  function automatic void chk(string n, longint a, longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endfunction

  function automatic bit m_ready();
    return (m_st == 0) && (rob.size() <= DEPTH - LANES);
  endfunction

  // Abstract ROB: program-ordered queue, retire from the front
  function automatic void model_step();
    int ce;
    bit rdy, fl, hl;
    ent_t e;
    ce  = edge_n + 1;
    rdy = m_ready();
    fl  = 0;
    hl  = 0;
    if (m_st == 1) begin m_st = 0; return; end
    if (m_st == 2) return;
    for (int k = 0; k < LANES && rob.size() > 0 && rob[0].done; k++) begin
      e = rob.pop_front();
      if (e.flush) begin
        expq.push_back('{ce, 1, k, 0, e.value, e.tag});
        fl = 1;
        break;
      end
      if (e.halt) begin hl = 1; break; end
      expq.push_back('{ce, 0, k, e.dest, e.value, e.tag});
    end
    for (int i = 0; i < LANES; i++) begin
      if (bus.cdb_valid[i]) begin
        foreach (rob[j]) begin
          if (rob[j].tag == int'(bus.cdb_tag[i*TAG_W +: TAG_W])) begin
            rob[j].done  = 1;
            rob[j].flush = bus.cdb_flush[i];
            rob[j].value = int'(bus.cdb_value[i*DATA_W +: DATA_W]);
          end
        end
      end
    end
    if (fl) begin
      rob.delete();
      m_aptr = 0;
      m_st = 1;
      return;
    end
    if (rdy) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.alloc_valid[i]) begin
          rob.push_back('{m_aptr, int'(bus.alloc_dest[i*REG_W +: REG_W]),
                          bus.alloc_halt[i], 0, bus.alloc_halt[i], 0});
          m_aptr = (m_aptr + 1) % DEPTH;
        end
      end
    end
    if (hl) m_st = 2;
  endfunction

  always @(posedge clk) begin
    logic [LANES-1:0] seen;
    bit fseen;
    exp_t x;
    edge_n++;
    #1;
    if (rst_n && chk_on) begin
      seen  = '0;
      fseen = 0;
      while (expq.size() > 0 && expq[0].cyc <= edge_n) begin
        x = expq.pop_front();
        if (x.cyc != edge_n) chk("exp_cycle", edge_n, x.cyc);
        if (x.fl) begin
          fseen = 1;
          chk("flush_valid", bus.flush_valid, 1);
          chk("flush_target", bus.flush_target, x.data);
        end else begin
          seen[x.lane] = 1'b1;
          chk($sformatf("commit_dest[%0d]", x.lane),
              bus.commit_dest[x.lane*REG_W +: REG_W], x.dest);
          chk($sformatf("commit_data[%0d]", x.lane),
              bus.commit_data[x.lane*DATA_W +: DATA_W], x.data);
          chk($sformatf("commit_tag[%0d]", x.lane),
              bus.commit_tag[x.lane*TAG_W +: TAG_W], x.tag);
        end
      end
      chk("commit_valid", bus.commit_valid, seen);
      if (!fseen) chk("flush_idle", bus.flush_valid, 0);
      chk("count", bus.count, rob.size());
      chk("alloc_ready", bus.alloc_ready, m_ready());
      chk("alloc_tag", bus.alloc_tag, m_aptr);
      chk("empty", bus.empty, rob.size() == 0);
      chk("full", bus.full, rob.size() == DEPTH);
      chk("halted", bus.halted, m_st == 2);
    end
  end

  task automatic idle();
    bus.alloc_valid = '0;
    bus.alloc_dest  = '0;
    bus.alloc_halt  = '0;
    bus.cdb_valid   = '0;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
    bus.cdb_flush   = '0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    idle();
  endtask

  task automatic set_alloc(int n, logic [LANES-1:0] hm, int dbase);
    for (int i = 0; i < n; i++) begin
      bus.alloc_valid[i] = 1'b1;
      bus.alloc_halt[i]  = hm[i];
      bus.alloc_dest[i*REG_W +: REG_W] =
        REG_W'(dbase < 0 ? $urandom_range(0, 15) : dbase + i);
    end
  endtask

  task automatic set_cdb(int l, int tag, int val, bit fl);
    bus.cdb_valid[l] = 1'b1;
    bus.cdb_tag[l*TAG_W +: TAG_W]    = TAG_W'(tag);
    bus.cdb_value[l*DATA_W +: DATA_W] = DATA_W'(val);
    bus.cdb_flush[l] = fl;
  endtask

  task automatic cdb_pending();
    int l;
    l = 0;
    foreach (rob[j]) begin
      if (!rob[j].done && l < LANES) begin
        set_cdb(l, rob[j].tag, $urandom_range(0, 65535), 0);
        l++;
      end
    end
  endtask

  task automatic drain(int cycles);
    for (int c = 0; c < cycles; c++) begin
      cdb_pending();
      tick();
    end
  endtask

  task automatic model_clear();
    rob.delete();
    expq.delete();
    m_aptr = 0;
    m_st = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset();
    chk("rst_commit_valid", bus.commit_valid, 0);
    chk("rst_commit_dest", bus.commit_dest, 0);
    chk("rst_commit_data", bus.commit_data, 0);
    chk("rst_commit_tag", bus.commit_tag, 0);
    chk("rst_flush_valid", bus.flush_valid, 0);
    chk("rst_flush_target", bus.flush_target, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_alloc_tag", bus.alloc_tag, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    chk_on = 1;

    // out-of-order completion, one 4-wide retire
    set_alloc(4, '0, 1); tick();
    for (int t = 3; t >= 0; t--) begin
      set_cdb(0, t, 16'h100 + t, 0);
      tick();
    end
    repeat (3) tick();

    // fill to full, backpressure, wrap through tag 15 -> 0
    for (int c = 0; c < 5; c++) begin set_alloc(4, '0, -1); tick(); end
    set_cdb(0, rob[0].tag, 16'hbeef, 0); tick();
    for (int c = 0; c < 8; c++) begin
      set_alloc(4, '0, -1);
      set_cdb(0, rob[c % 4].tag, $urandom_range(0, 65535), 0);
      tick();
    end
    drain(12);
    repeat (3) tick();

    // wrapped alloc group 14,15,0,1 retiring together
    do_reset();
    for (int c = 0; c < 4; c++) begin set_alloc(c < 3 ? 4 : 2, '0, -1); tick(); end
    drain(6);
    repeat (3) tick();
    set_alloc(4, '0, -1); tick();
    cdb_pending(); tick();
    repeat (3) tick();

    // mispredict at entry 1
    do_reset();
    set_alloc(4, '0, 5); tick();
    set_cdb(0, 0, 16'h0011, 0);
    set_cdb(1, 1, 16'h0040, 1);
    set_cdb(2, 2, 16'h0022, 0);
    set_cdb(3, 3, 16'h0033, 0);
    tick();
    set_alloc(4, '0, -1); tick();
    set_alloc(4, '0, -1); tick();
    set_alloc(4, '0, -1); tick();
    drain(3);
    repeat (2) tick();

    // halt at entry 2, then ignored traffic
    do_reset();
    set_alloc(4, 4'b0100, -1); tick();
    set_cdb(0, 0, 16'h0aaa, 0);
    set_cdb(1, 1, 16'h0bbb, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      set_alloc(4, '0, -1);
      set_cdb(0, 3, $urandom_range(0, 65535), 0);
      tick();
    end

    // async reset during a commit with 10 entries held
    do_reset();
    set_alloc(4, '0, -1); tick();
    set_alloc(4, '0, -1); tick();
    set_alloc(2, '0, -1); tick();
    for (int l = 0; l < LANES; l++) set_cdb(l, l, 16'h0300 + l, 0);
    tick();
    model_step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      logic [LANES-1:0] hm;
      int r;
      if (m_st == 2 && $urandom_range(0, 3) == 0) do_reset();
      for (int i = 0; i < LANES; i++) hm[i] = ($urandom_range(0, 199) == 0);
      set_alloc($urandom_range(0, 4), hm, -1);
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (rob.size() > 0 && $urandom_range(0, 3) != 0)
            r = rob[$urandom_range(0, rob.size() - 1)].tag;
          else
            r = $urandom_range(0, DEPTH - 1);
          set_cdb(l, r, $urandom_range(0, 65535), $urandom_range(0, 39) == 0);
        end
      end
      tick();
    end

    drain(10);
    repeat (3) tick();
    chk("exp_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
